// File: rtl/periph_uart_tx.sv
// periph_uart_tx: request-driven 8N1 UART transmitter with a small TX FIFO.
// Define PERIPH_UART_TX_PARITY_EN to add an even parity bit (11-bit frame).
module periph_uart_tx #(
  parameter int OUTPUT_PERIPH_LEN = 'h20,
  parameter int CLKS_PER_BIT      = 16,
  parameter int FIFO_DEPTH        = 4,
  parameter int TX_DATA_ADDR      = 'h10,
  parameter int TX_REQ_ADDR       = 'h11,
  parameter int TX_CTRL_ADDR      = 'h12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] output_peripherals_mem [OUTPUT_PERIPH_LEN],
  output logic [7:0] status_byte,
  output logic       tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

`ifdef PERIPH_UART_TX_PARITY_EN
  localparam logic PAR_ADV = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  localparam logic PAR_ADV = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            armed_q;
  logic [7:0]      last_req_q;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      status_q, status_d;
  logic            req_seen, push, pop, bit_end;

  assign tx          = tx_q;
  assign status_byte = status_q;

  // Request edge detection and accept/drop decision against pre-pop count.
  always_comb begin
    req_seen = armed_q &&
      (output_peripherals_mem[TX_REQ_ADDR] != last_req_q);
    push     = req_seen && (cnt_q != CNT_FULL);
  end

  // Serializer next state, bit timing and FIFO pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bit_end = (baud_q == BAUD_LAST);
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          sh_d    = fifo_q[rptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef PERIPH_UART_TX_PARITY_EN
            tx_d    = ^sh_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[bit_q + 3'd1];
          end
        end
      end
`ifdef PERIPH_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            sh_d    = fifo_q[rptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters, sticky overflow (clear wins) and the status image.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    acc_d = push ? acc_q + 4'd1 : acc_q;
    ovf_d = ovf_q;
    if (output_peripherals_mem[TX_CTRL_ADDR][0]) begin
      ovf_d = 1'b0;
    end else if (req_seen && !push) begin
      ovf_d = 1'b1;
    end
    status_d = {acc_d, PAR_ADV, ovf_d, (cnt_d == CNT_FULL),
                ((state_d != S_IDLE) || (cnt_d != '0))};
  end

  // Control and serializer state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      armed_q    <= 1'b0;
      last_req_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      armed_q    <= 1'b1;
      last_req_q <= output_peripherals_mem[TX_REQ_ADDR];
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      status_q   <= status_d;
    end
  end

  // FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wptr_q] <= output_peripherals_mem[TX_DATA_ADDR];
    end
  end

endmodule

// File: tb/tb_periph_uart_tx.sv
// tb_periph_uart_tx: directed frame vectors plus burst, overflow,
// arming and mid-frame reset sequences for periph_uart_tx.
module tb_periph_uart_tx;

  localparam int CPB = 4;
  localparam int LEN = 'h20;
`ifdef PERIPH_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [7:0] PARB = 8'h08;
`else
  localparam int NB = 10;
  localparam logic [7:0] PARB = 8'h00;
`endif
  localparam int FC = NB * CPB;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] win [LEN];
  logic [7:0] status_byte;
  logic       tx;

  int errs = 0;
  int checks = 0;
  int acc = 0;

  always #5 clock = ~clock;

  periph_uart_tx #(
    .OUTPUT_PERIPH_LEN(LEN),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4),
    .TX_DATA_ADDR('h10),
    .TX_REQ_ADDR('h11),
    .TX_CTRL_ADDR('h12)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .output_peripherals_mem(win),
    .status_byte(status_byte),
    .tx(tx)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] st(input int a, input logic ovf,
                                    input logic full, input logic busy);
    logic [3:0] a4;
    a4 = a[3:0];
    return {a4, 1'b0, ovf, full, busy} | PARB;
  endfunction

  task automatic req(input logic [7:0] d);
    win['h10] = d;
    win['h11] = win['h11] + 8'd1;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (tx !== 1'b0 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Samples one frame every cycle, starting at the current (first low) one.
  task automatic cap_frame(input logic [10:0] exp, output int bad);
    bad = 0;
    for (int j = 0; j < FC; j++) begin
      if (j > 0) @(negedge clock);
      if (tx !== exp[j / CPB]) bad++;
    end
  endtask

  vec_t vecs [5];
  logic [10:0] burst [5];

  initial begin
    int lat;
    int bad;
    int f;
    int n;
`ifdef PERIPH_UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 11'h4AA};
    vecs[1] = '{8'h00, 11'h400};
    vecs[2] = '{8'hFF, 11'h5FE};
    vecs[3] = '{8'h07, 11'h60E};
    vecs[4] = '{8'h80, 11'h700};
    burst   = '{11'h478, 11'h540, 11'h742, 11'h744, 11'h546};
`else
    vecs[0] = '{8'h55, 11'h2AA};
    vecs[1] = '{8'h00, 11'h200};
    vecs[2] = '{8'hFF, 11'h3FE};
    vecs[3] = '{8'h07, 11'h20E};
    vecs[4] = '{8'h80, 11'h300};
    burst   = '{11'h278, 11'h340, 11'h342, 11'h344, 11'h346};
`endif
    for (int i = 0; i < LEN; i++) win[i] = 8'h00;
    win['h11] = 8'h7E;

    // Reset state, then release with a stale request byte present.
    repeat (2) @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_status", status_byte, 8'h00);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || status_byte !== PARB) bad++;
    end
    chk("arm_no_send", bad, 0);

    // Single-frame vectors.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req(vecs[i].data);
      acc++;
      wait_start(lat);
      chk("vec_latency", lat, 2);
      cap_frame(vecs[i].frame, bad);
      chk("vec_frame", bad, 0);
      chk("vec_busy_stop", status_byte, st(acc, 0, 0, 1));
      @(negedge clock);
      chk("vec_idle", {tx, status_byte}, {1'b1, st(acc, 0, 0, 0)});
    end

    // Burst of five while busy: four queued back-to-back, fifth dropped.
    @(negedge clock);
    req(8'h3C);
    acc++;
    wait_start(lat);
    chk("burst_latency", lat, 2);
    bad = 0;
    for (int j = 0; j < 5 * FC; j++) begin
      if (j > 0) @(negedge clock);
      f = j / FC;
      if (tx !== burst[f][(j % FC) / CPB]) bad++;
      if (j == 8) chk("burst_full", status_byte, st(acc + 4, 0, 1, 1));
      if (j == 9) chk("burst_ovf", status_byte, st(acc + 4, 1, 1, 1));
      if (j >= 4 && j <= 8) req(8'hA0 + 8'(j - 4));
    end
    acc += 4;
    chk("burst_frames", bad, 0);
    @(negedge clock);
    chk("burst_end", status_byte, st(acc, 1, 0, 0));

    // Overflow clear, then clear winning over a same-edge drop.
    win['h12] = 8'h01;
    @(negedge clock);
    win['h12] = 8'h00;
    chk("ovf_clear", status_byte, st(acc, 0, 0, 0));
    req(8'hB0);
    acc++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      req(8'hB0 + 8'(k));
      acc++;
    end
    @(negedge clock);
    chk("fill_full", status_byte, st(acc, 0, 1, 1));
    req(8'hBF);
    win['h12] = 8'h01;
    @(negedge clock);
    win['h12] = 8'h00;
    chk("clear_wins", status_byte, st(acc, 0, 1, 1));
    n = 0;
    while (status_byte[0] !== 1'b0 && n < 6 * FC) begin
      @(negedge clock);
      n++;
    end
    chk("drain", status_byte, st(acc, 0, 0, 0));

    // Reset in the third data bit of 0xFF.
    @(negedge clock);
    req(8'hFF);
    wait_start(lat);
    chk("ff_latency", lat, 2);
    repeat (13) @(negedge clock);
    chk("ff_bit2", tx, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_status", status_byte, 8'h00);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    acc = 0;
    bad = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || status_byte !== PARB) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    // A fresh request after re-arming sends exactly one frame.
    req(vecs[4].data);
    acc++;
    wait_start(lat);
    chk("rearm_latency", lat, 2);
    cap_frame(vecs[4].frame, bad);
    chk("rearm_frame", bad, 0);
    bad = 0;
    for (int i = 0; i < 2 * FC; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    chk("rearm_single", bad, 0);
    chk("rearm_status", status_byte, st(acc, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
